// File: rtl/i2s_pkg.sv
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared frame geometry and channel encoding for the I2S transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int MSB_POS    = 1;
  localparam int LSB_POS    = 24;

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int POS_W = $clog2(SLOT_BITS);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// Module   : i2s_clk_gen
// Purpose  : Divides clk into the I2S bit clock and tracks the 64-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_sclk,
  output logic             o_sclk_fall,
  output logic             o_frame_start,
  output logic [CNT_W-1:0] o_bit_cnt_next
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_div_wrap;
  logic             w_sclk_fall;

  assign w_div_wrap  = (r_div_cnt == C_DIV_LAST);
  assign w_sclk_fall = w_div_wrap & r_sclk;

  // bit_cnt resets to the last slot so the first falling event opens a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_bit_cnt <= '1;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_sclk    <= ~r_sclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_sclk_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign o_sclk         = r_sclk;
  assign o_sclk_fall    = w_sclk_fall;
  assign o_frame_start  = w_sclk_fall & (r_bit_cnt == '1);
  assign o_bit_cnt_next = r_bit_cnt + 1'b1;

endmodule

`default_nettype wire

// File: rtl/i2s_transmitter.sv
// ============================================================================
// Module   : i2s_transmitter
// Purpose  : I2S master serializing 24-bit stereo samples, MSB one Sclk after Lrck.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [SAMPLE_W-1:0] L_In,
  input  logic [SAMPLE_W-1:0] R_In,
  output logic                Sclk,
  output logic                Lrck,
  output logic                Sdata,
  output logic                Sample_Req
);

  logic                w_sclk_fall;
  logic                w_frame_start;
  logic [CNT_W-1:0]    w_bit_cnt_next;
  logic [POS_W-1:0]    w_pos;
  channel_e            w_chan;
  logic                w_in_word;
  logic                w_sdata_next;

  logic [SAMPLE_W-1:0] r_left_sr;
  logic [SAMPLE_W-1:0] r_right_sr;
  logic                r_en_frame;
  logic                r_lrck;
  logic                r_sdata;
  logic                r_sample_req;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk            (Clk),
    .rst            (Reset),
    .o_sclk         (Sclk),
    .o_sclk_fall    (w_sclk_fall),
    .o_frame_start  (w_frame_start),
    .o_bit_cnt_next (w_bit_cnt_next)
  );

  // Everything below is decided for the slot position being entered
  assign w_pos     = w_bit_cnt_next[POS_W-1:0];
  assign w_chan    = channel_e'(w_bit_cnt_next[CNT_W-1]);
  assign w_in_word = (w_pos >= POS_W'(MSB_POS)) && (w_pos <= POS_W'(LSB_POS));

  assign w_sdata_next = w_in_word & r_en_frame &
                        ((w_chan == CH_LEFT) ? r_left_sr[SAMPLE_W-1] : r_right_sr[SAMPLE_W-1]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_left_sr    <= '0;
      r_right_sr   <= '0;
      r_en_frame   <= 1'b0;
      r_lrck       <= 1'b1;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
    end else begin
      r_sample_req <= w_frame_start;
      if (w_frame_start) begin
        r_left_sr  <= L_In;
        r_right_sr <= R_In;
        r_en_frame <= Enable;
      end else if (w_sclk_fall && w_in_word) begin
        if (w_chan == CH_LEFT) begin
          r_left_sr <= r_left_sr << 1;
        end else begin
          r_right_sr <= r_right_sr << 1;
        end
      end
      if (w_sclk_fall) begin
        r_lrck  <= (w_chan == CH_RIGHT);
        r_sdata <= w_sdata_next;
      end
    end
  end

  assign Lrck       = r_lrck;
  assign Sdata      = r_sdata;
  assign Sample_Req = r_sample_req;

endmodule

`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
// ============================================================================
// Module   : tb_i2s_transmitter
// Purpose  : Directed, table-driven check of i2s_transmitter at CLK_DIV 4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_transmitter;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        en;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, en4, sclk4, lrck4, sdata4, req4;
  logic [23:0] l4, r4;
  logic        rst1, en1, sclk1, lrck1, sdata1, req1;
  logic [23:0] l1, r1;
  logic        sel;

  i2s_transmitter #(.CLK_DIV(4)) dut4 (
    .Clk(clk), .Reset(rst4), .Enable(en4), .L_In(l4), .R_In(r4),
    .Sclk(sclk4), .Lrck(lrck4), .Sdata(sdata4), .Sample_Req(req4)
  );

  i2s_transmitter #(.CLK_DIV(1)) dut1 (
    .Clk(clk), .Reset(rst1), .Enable(en1), .L_In(l1), .R_In(r1),
    .Sclk(sclk1), .Lrck(lrck1), .Sdata(sdata1), .Sample_Req(req1)
  );

  wire m_sclk  = sel ? sclk1  : sclk4;
  wire m_lrck  = sel ? lrck1  : lrck4;
  wire m_sdata = sel ? sdata1 : sdata4;
  wire m_req   = sel ? req1   : req4;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst1 = v;
    else     rst4 = v;
  endtask

  task automatic wait_req(output longint at);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (m_req !== 1'b1 && n < 3000);
    if (m_req !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got no Sample_Req within %0d cycles", n);
    end
    at = cyc;
  endtask

  // Records Sdata/Lrck at each Sclk rise of one frame; counts output changes
  // that do not coincide with an Sclk fall. Optional mid-frame input change.
  task automatic capture(input int chg_pos, input logic [23:0] chg_l, input logic chg_en,
                         output logic [63:0] sd, output logic [63:0] lr, output int glitches);
    logic prev_sclk, prev_sd, prev_lr;
    int   n;
    sd = '0; lr = '0; glitches = 0; n = 0;
    for (int k = 0; k < 64; k++) begin
      do begin
        prev_sclk = m_sclk; prev_sd = m_sdata; prev_lr = m_lrck;
        tick();
        n++;
        if (!(prev_sclk && !m_sclk) && (m_sdata !== prev_sd || m_lrck !== prev_lr))
          glitches++;
      end while (!(!prev_sclk && m_sclk) && n < 2000);
      sd[k] = m_sdata;
      lr[k] = m_lrck;
      if (k == chg_pos) begin
        l4  = chg_l;
        en4 = chg_en;
      end
    end
    if (n >= 2000) glitches += 1000;
  endtask

  task automatic check_frame(input string tag, input logic [63:0] sd, input logic [63:0] lr,
                             input int gl, input logic [23:0] exp_l, input logic [23:0] exp_r);
    logic [23:0] lw, rw;
    logic [63:0] pad_mask;
    for (int p = 1; p <= 24; p++) begin
      lw[24-p] = sd[p];
      rw[24-p] = sd[32+p];
    end
    for (int k = 0; k < 64; k++) pad_mask[k] = ((k % 32) == 0) || ((k % 32) > 24);
    check({tag, "_left"},  {40'd0, lw}, {40'd0, exp_l});
    check({tag, "_right"}, {40'd0, rw}, {40'd0, exp_r});
    check({tag, "_pad"},   sd & pad_mask, 64'd0);
    check({tag, "_lrck"},  lr, 64'hFFFF_FFFF_0000_0000);
    check({tag, "_align"}, 64'(gl), 64'd0);
  endtask

  // Holds reset, checks reset outputs, then checks post-release edge timing.
  task automatic reset_seq(input int div, input int hold, input string tag);
    int     first_req, first_lrck0, first_sclk1;
    logic   req_after;
    longint t_edge, t_next;
    set_rst(1'b1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_rst_out"}, {60'd0, m_sclk, m_lrck, m_sdata, m_req}, 64'h4);
    end
    set_rst(1'b0);
    first_req = 0; first_lrck0 = 0; first_sclk1 = 0; req_after = 1'bx; t_edge = cyc;
    for (int e = 1; e <= 2*div + 1; e++) begin
      tick();
      if (m_req === 1'b1 && first_req == 0) begin first_req = e; t_edge = cyc; end
      if (m_lrck === 1'b0 && first_lrck0 == 0) first_lrck0 = e;
      if (m_sclk === 1'b1 && first_sclk1 == 0) first_sclk1 = e;
      if (e == 2*div + 1) req_after = m_req;
    end
    check({tag, "_req_edge"},  64'(first_req),   64'(2*div));
    check({tag, "_lrck_edge"}, 64'(first_lrck0), 64'(2*div));
    check({tag, "_sclk_edge"}, 64'(first_sclk1), 64'(div));
    check({tag, "_req_width"}, {63'd0, req_after}, 64'd0);
    wait_req(t_next);
    check({tag, "_req_period"}, 64'(t_next - t_edge), 64'(128*div));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    logic [63:0] sd, lr;
    int          gl;
    longint      t0, t1, t2;
    logic [5:0]  sclk_seq;

    rst4 = 1'b1; en4 = 1'b0; l4 = '0; r4 = '0;
    rst1 = 1'b1; en1 = 1'b0; l1 = '0; r1 = '0;
    sel  = 1'b0;

    vecs[0] = '{l: 24'hA5A5A5, r: 24'h3C3C3C, en: 1'b1, exp_l: 24'hA5A5A5, exp_r: 24'h3C3C3C};
    vecs[1] = '{l: 24'h800000, r: 24'h000001, en: 1'b1, exp_l: 24'h800000, exp_r: 24'h000001};
    vecs[2] = '{l: 24'h7FFFFF, r: 24'hFFFFFF, en: 1'b1, exp_l: 24'h7FFFFF, exp_r: 24'hFFFFFF};
    vecs[3] = '{l: 24'h123456, r: 24'h654321, en: 1'b0, exp_l: 24'h000000, exp_r: 24'h000000};

    reset_seq(4, 2, "d4_reset");

    for (int i = 0; i < 4; i++) begin
      l4 = vecs[i].l; r4 = vecs[i].r; en4 = vecs[i].en;
      wait_req(t0);
      capture(-1, l4, en4, sd, lr, gl);
      check_frame($sformatf("vec%0d", i), sd, lr, gl, vecs[i].exp_l, vecs[i].exp_r);
    end

    // L_In change mid-frame only reaches the following frame
    l4 = 24'h000001; r4 = 24'h000000; en4 = 1'b1;
    wait_req(t0);
    capture(10, 24'h7FFFFF, 1'b1, sd, lr, gl);
    check_frame("lchg_cur", sd, lr, gl, 24'h000001, 24'h000000);
    wait_req(t0);
    capture(-1, l4, en4, sd, lr, gl);
    check_frame("lchg_next", sd, lr, gl, 24'h7FFFFF, 24'h000000);

    // Enable dropped in the right slot: current frame completes, next is muted
    l4 = 24'hABCDEF; r4 = 24'h5A5A5A; en4 = 1'b1;
    wait_req(t0);
    capture(40, 24'hABCDEF, 1'b0, sd, lr, gl);
    check_frame("endrop_cur", sd, lr, gl, 24'hABCDEF, 24'h5A5A5A);
    wait_req(t1);
    capture(-1, l4, en4, sd, lr, gl);
    check_frame("endrop_next", sd, lr, gl, 24'h000000, 24'h000000);
    check("endrop_sdata_zero", sd, 64'd0);
    wait_req(t2);
    check("endrop_period1", 64'(t1 - t0), 64'd512);
    check("endrop_period2", 64'(t2 - t1), 64'd512);

    // One-cycle reset at bit_cnt 20 while Sclk high, Lrck low, Sdata high
    l4 = 24'hFFFFFF; en4 = 1'b1;
    wait_req(t0);
    wait_req(t0);
    for (int i = 0; i < 8*20 + 5; i++) tick();
    check("midrst_pre", {61'd0, sclk4, lrck4, sdata4}, 64'h5);
    reset_seq(4, 1, "d4_midrst");

    // CLK_DIV = 1 instance
    sel = 1'b1;
    reset_seq(1, 2, "d1_reset");
    l1 = 24'h800001; r1 = 24'h000000; en1 = 1'b1;
    wait_req(t0);
    for (int i = 0; i < 6; i++) begin
      tick();
      sclk_seq[i] = m_sclk;
    end
    check("d1_sclk_toggle", {58'd0, sclk_seq}, 64'h15);
    wait_req(t1);
    check("d1_req_period", 64'(t1 - t0), 64'd128);
    capture(-1, l1, en1, sd, lr, gl);
    check_frame("d1_frame", sd, lr, gl, 24'h800001, 24'h000000);
    check("d1_left_slot", {32'd0, sd[31:0]}, 64'h0000_0000_0100_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes processed 24-bit stereo samples from the pedal chain onto a standard I2S link toward the codec DAC. It sits after the last effect stage and generates the bit clock (Sclk) and word clock (Lrck) as master from the system clock. It also emits a one-cycle frame strobe so upstream effects that run per sample can advance in lockstep with the DAC.

## Interface
- CLK_DIV, 4, Clk cycles per Sclk half-period; integer ≥ 1. Frame length = 128·CLK_DIV Clk cycles.
- Clk  in  1  system/master clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- Enable  in  1  1 = transmit samples, 0 = mute (Sdata held 0); clocks always run
- L_In  in  24  left sample, two's complement
- R_In  in  24  right sample, two's complement
- Sclk  out  1  I2S bit clock
- Lrck  out  1  I2S word select; 0 = left, 1 = right
- Sdata  out  1  I2S serial data, MSB first
- Sample_Req  out  1  one-Clk pulse at frame start, on the edge where L_In/R_In are latched

## Operation
- Divider counter div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and Sclk toggles. A 1→0 toggle is a falling event.
- Frame counter bit_cnt, 6 bits, 0..63, advances on each falling event and wraps 63→0.
- Slot position p = bit_cnt[4:0]. Channel = bit_cnt[5].
- On the falling event where bit_cnt wraps to 0, in the same edge:
  - latch L_In into left shift reg and R_In into right shift reg;
  - sample Enable into en_frame;
  - pulse Sample_Req.
- Lrck updates on every falling event to the new bit_cnt[5]. Transitions occur at bit_cnt 0 and 32.
- Sdata on each falling event, for the new position:
  - p = 1..24 and en_frame = 1: word bit (24-p) of the active channel register, so MSB at p = 1 and LSB at p = 24;
  - p = 0, p = 25..31, or en_frame = 0: 0.
- Changes to L_In/R_In/Enable mid-frame have no effect until the next frame start.
- Reset values: Sclk=0, Lrck=1, Sdata=0, Sample_Req=0, div_cnt=0, bit_cnt=63, shift regs=0, en_frame=0.
- Reset asserted mid-frame forces all reset values on that edge. The frame restarts cleanly after release; the partial frame is discarded.

## Timing
- All outputs are registered and update only on Clk rising edges.
- After Reset deasserts, number subsequent edges 1, 2, …:
  - edge CLK_DIV: Sclk→1;
  - edge 2·CLK_DIV: Sclk→0, bit_cnt→0, Lrck→0, Sdata→0, Sample_Req=1 for exactly that cycle.
- Sample_Req period is 128·CLK_DIV Clk cycles, independent of Enable.
- Sclk duty is 50%. Sdata and Lrck change only coincident with Sclk falling, so they are stable for the DAC at Sclk rising.
- Latency from latch to the MSB on Sdata is 2·CLK_DIV Clk cycles (one Sclk period). The left LSB appears 24 Sclk periods after latch; the right MSB appears 33 Sclk periods after latch.

## Structure
- Package i2s_pkg holds:
  - SAMPLE_W = 24, SLOT_BITS = 32, FRAME_BITS = 64;
  - MSB_POS = 1, LSB_POS = 24;
  - a channel enum (CH_LEFT = 0, CH_RIGHT = 1).
- Sub-module i2s_clk_gen: div_cnt, Sclk, bit_cnt. Exports sclk_fall and frame_start strobes.
- Top level holds the shift registers, en_frame, and Sdata/Lrck/Sample_Req registers.

## Test plan
- Reset, CLK_DIV=4: while Reset=1, Sclk=0, Lrck=1, Sdata=0, Sample_Req=0. After release, Sample_Req=1 only on edge 8 and Lrck falls on edge 8; next pulse on edge 520.
- Enable=1, L_In=24'hA5A5A5, R_In=24'h3C3C3C: sampled at each Sclk rise, left slot p1..24 = A5A5A5 MSB first and right slot = 3C3C3C. p0 and p25..31 are 0. Lrck=0 for bits 0..31 and 1 for bits 32..63.
- L_In changed from 24'h000001 to 24'h7FFFFF at bit_cnt 10: current frame still sends 000001, next frame sends 7FFFFF.
- Enable dropped at bit_cnt 40: current right slot is still transmitted. The next frame's Sdata is constant 0, while Sclk/Lrck/Sample_Req continue unchanged.
- Reset pulsed one cycle at bit_cnt 20: reset values on that edge, and a re-run of the scenario-1 timing after release.
- CLK_DIV=1, L_In=24'h800001: Sclk period 2 Clk, Sample_Req every 128 Clk. Left slot Sdata=1 only at p1 and p24.
